fractal_sync_arbiter: RTL and testbench

FRACTAL_SYNC_ARBITER -- requirements
Module: fractal_sync_arbiter

---
 rtl/fractal_sync_arbiter.sv | 105 ++++++++++
 tb/tb_fractal_sync_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/fractal_sync_arbiter.sv
// fractal_sync_arbiter
//   Two-input barrier-sync arbiter for one node of the fractal sync tree.
//   Requests arrive from the east/north (EN) and west/south (WS) children and
//   are forwarded upstream through a single output register.
//   Identical requests (same id and aggr) arriving together are merged into
//   one upstream request tagged SD_BOTH.
//   Non-identical simultaneous requests are round-robin arbitrated.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   en_req_i/aggr/id      EN child request;  en_ready_o accepts it
//   ws_req_i/aggr/id      WS child request;  ws_ready_o accepts it
//   req_o/aggr_o/id_o     registered upstream request
//   sd_o                  source mask: 01 EN, 10 WS, 11 both
//   ready_i               upstream accepts req_o this cycle
module fractal_sync_arbiter #(
  parameter int AGGR_W = 4,
  parameter int ID_W   = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_req_i,
  input  logic [AGGR_W-1:0] en_aggr_i,
  input  logic [ID_W-1:0]   en_id_i,
  output logic              en_ready_o,
  input  logic              ws_req_i,
  input  logic [AGGR_W-1:0] ws_aggr_i,
  input  logic [ID_W-1:0]   ws_id_i,
  output logic              ws_ready_o,
  output logic              req_o,
  output logic [AGGR_W-1:0] aggr_o,
  output logic [ID_W-1:0]   id_o,
  output logic [1:0]        sd_o,
  input  logic              ready_i
);

  localparam logic [1:0] SD_NONE       = 2'b00;
  localparam logic [1:0] SD_EST_NORTH  = 2'b01;
  localparam logic [1:0] SD_WEST_SOUTH = 2'b10;
  localparam logic [1:0] SD_BOTH       = 2'b11;

  logic              out_valid;
  logic [AGGR_W-1:0] aggr_q;
  logic [ID_W-1:0]   id_q;
  logic [1:0]        sd_q;
  logic              rr_q;

  logic load;
  logic merge;
  logic grant_en;
  logic grant_ws;

  // The register can take a new entry when it is empty or being drained this
  // cycle, which gives back-to-back transfers without a bubble.
  assign load  = !out_valid || ready_i;

  assign merge = load && en_req_i && ws_req_i &&
                 (en_id_i == ws_id_i) && (en_aggr_i == ws_aggr_i);

  // On a merge both grants are high. Otherwise a lone request wins outright
  // and a contended cycle goes to the side rr_q points at (0 = EN, 1 = WS).
  assign grant_en = load && en_req_i && (merge || !ws_req_i || !rr_q);
  assign grant_ws = load && ws_req_i && (merge || !en_req_i ||  rr_q);

  assign en_ready_o = grant_en && !rst_i;
  assign ws_ready_o = grant_ws && !rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid <= 1'b0;
      aggr_q    <= '0;
      id_q      <= '0;
      sd_q      <= SD_NONE;
      rr_q      <= 1'b0;
    end else if (load) begin
      if (merge) begin
        out_valid <= 1'b1;
        aggr_q    <= en_aggr_i;
        id_q      <= en_id_i;
        sd_q      <= SD_BOTH;
      end else if (grant_en) begin
        out_valid <= 1'b1;
        aggr_q    <= en_aggr_i;
        id_q      <= en_id_i;
        sd_q      <= SD_EST_NORTH;
        rr_q      <= 1'b1;
      end else if (grant_ws) begin
        out_valid <= 1'b1;
        aggr_q    <= ws_aggr_i;
        id_q      <= ws_id_i;
        sd_q      <= SD_WEST_SOUTH;
        rr_q      <= 1'b0;
      end else begin
        // Nothing to load: drop valid, keep last data for observability.
        out_valid <= 1'b0;
      end
    end
  end

  assign req_o  = out_valid;
  assign aggr_o = aggr_q;
  assign id_o   = id_q;
  assign sd_o   = sd_q;

endmodule

// File: tb/tb_fractal_sync_arbiter.sv
// Directed testbench for fractal_sync_arbiter.
// Inputs change 1 time unit after the rising edge; ready outputs are checked
// at the falling edge, registered outputs 1 time unit after the rising edge.
module tb_fractal_sync_arbiter;

  localparam int AGGR_W = 4;
  localparam int ID_W   = 8;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              en_req_i;
  logic [AGGR_W-1:0] en_aggr_i;
  logic [ID_W-1:0]   en_id_i;
  logic              en_ready_o;
  logic              ws_req_i;
  logic [AGGR_W-1:0] ws_aggr_i;
  logic [ID_W-1:0]   ws_id_i;
  logic              ws_ready_o;
  logic              req_o;
  logic [AGGR_W-1:0] aggr_o;
  logic [ID_W-1:0]   id_o;
  logic [1:0]        sd_o;
  logic              ready_i;

  int checks = 0;
  int errors = 0;

  fractal_sync_arbiter #(.AGGR_W(AGGR_W), .ID_W(ID_W)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_req_i  (en_req_i),
    .en_aggr_i (en_aggr_i),
    .en_id_i   (en_id_i),
    .en_ready_o(en_ready_o),
    .ws_req_i  (ws_req_i),
    .ws_aggr_i (ws_aggr_i),
    .ws_id_i   (ws_id_i),
    .ws_ready_o(ws_ready_o),
    .req_o     (req_o),
    .aggr_o    (aggr_o),
    .id_o      (id_o),
    .sd_o      (sd_o),
    .ready_i   (ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic er, input logic [AGGR_W-1:0] ea, input logic [ID_W-1:0] ei,
                       input logic wr, input logic [AGGR_W-1:0] wa, input logic [ID_W-1:0] wi,
                       input logic rdy);
    en_req_i = er; en_aggr_i = ea; en_id_i = ei;
    ws_req_i = wr; ws_aggr_i = wa; ws_id_i = wi;
    ready_i  = rdy;
  endtask

  task automatic chk_rdy(input string tag, input logic e, input logic w);
    @(negedge clk_i);
    chk({tag, ".en_ready"}, {31'd0, en_ready_o}, {31'd0, e});
    chk({tag, ".ws_ready"}, {31'd0, ws_ready_o}, {31'd0, w});
  endtask

  task automatic chk_out(input string tag, input logic r, input logic [ID_W-1:0] i,
                         input logic [AGGR_W-1:0] a, input logic [1:0] s);
    @(posedge clk_i);
    #1;
    chk({tag, ".req"},  {31'd0, r}, {31'd0, r === 1'bx ? 1'b0 : r} | 32'd0);
    chk({tag, ".req_o"}, {31'd0, req_o}, {31'd0, r});
    chk({tag, ".id"},   {24'd0, id_o},   {24'd0, i});
    chk({tag, ".aggr"}, {28'd0, aggr_o}, {28'd0, a});
    chk({tag, ".sd"},   {30'd0, sd_o},   {30'd0, s});
  endtask

  initial begin
    rst_i = 1'b1;
    drive(1'b1, 4'h1, 8'h05, 1'b1, 4'h2, 8'h06, 1'b1);

    // Reset: readies suppressed, register cleared.
    chk_rdy("rst", 1'b0, 1'b0);
    chk_out("rst", 1'b0, 8'h00, 4'h0, 2'b00);
    chk_rdy("rst2", 1'b0, 1'b0);
    chk_out("rst2", 1'b0, 8'h00, 4'h0, 2'b00);

    // Single EN request, one-cycle latency.
    rst_i = 1'b0;
    drive(1'b1, 4'h1, 8'h05, 1'b0, 4'h0, 8'h00, 1'b1);
    chk_rdy("en1", 1'b1, 1'b0);
    chk_out("en1", 1'b1, 8'h05, 4'h1, 2'b01);            // rr_q -> 1

    // Merge of identical requests; rr_q stays 1.
    drive(1'b1, 4'h3, 8'h22, 1'b1, 4'h3, 8'h22, 1'b1);
    chk_rdy("merge", 1'b1, 1'b1);
    chk_out("merge", 1'b1, 8'h22, 4'h3, 2'b11);

    // Contention right after merge: rr_q still 1, so WS wins.
    drive(1'b1, 4'h1, 8'h10, 1'b1, 4'h1, 8'h11, 1'b1);
    chk_rdy("rr_keep", 1'b0, 1'b1);
    chk_out("rr_keep", 1'b1, 8'h11, 4'h1, 2'b10);        // rr_q -> 0

    // Reset, then continuous contention alternates EN, WS, EN, WS.
    rst_i = 1'b1;
    drive(1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00, 1'b1);
    chk_out("rst3", 1'b0, 8'h00, 4'h0, 2'b00);
    rst_i = 1'b0;
    drive(1'b1, 4'h1, 8'h10, 1'b1, 4'h1, 8'h11, 1'b1);
    chk_rdy("alt0", 1'b1, 1'b0);
    chk_out("alt0", 1'b1, 8'h10, 4'h1, 2'b01);
    chk_rdy("alt1", 1'b0, 1'b1);
    chk_out("alt1", 1'b1, 8'h11, 4'h1, 2'b10);
    chk_rdy("alt2", 1'b1, 1'b0);
    chk_out("alt2", 1'b1, 8'h10, 4'h1, 2'b01);
    chk_rdy("alt3", 1'b0, 1'b1);
    chk_out("alt3", 1'b1, 8'h11, 4'h1, 2'b10);           // rr_q -> 0

    // Backpressure: full register, ready_i low for 5 cycles.
    ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk_rdy("stall", 1'b0, 1'b0);
      chk_out("stall", 1'b1, 8'h11, 4'h1, 2'b10);
    end
    ready_i = 1'b1;
    chk_rdy("unstall", 1'b1, 1'b0);
    chk_out("unstall", 1'b1, 8'h10, 4'h1, 2'b01);        // rr_q -> 1

    // Lone EN granted even though rr_q points at WS.
    drive(1'b1, 4'h2, 8'h44, 1'b0, 4'h0, 8'h00, 1'b1);
    chk_rdy("lone_en", 1'b1, 1'b0);
    chk_out("lone_en", 1'b1, 8'h44, 4'h2, 2'b01);        // rr_q -> 1
    drive(1'b0, 4'h0, 8'h00, 1'b1, 4'h5, 8'h33, 1'b1);
    chk_rdy("lone_ws", 1'b0, 1'b1);
    chk_out("lone_ws", 1'b1, 8'h33, 4'h5, 2'b10);        // rr_q -> 0

    // Same id, different aggr: no merge, EN then WS.
    drive(1'b1, 4'h1, 8'h07, 1'b1, 4'h2, 8'h07, 1'b1);
    chk_rdy("nomerge0", 1'b1, 1'b0);
    chk_out("nomerge0", 1'b1, 8'h07, 4'h1, 2'b01);
    drive(1'b0, 4'h1, 8'h07, 1'b1, 4'h2, 8'h07, 1'b1);
    chk_rdy("nomerge1", 1'b0, 1'b1);
    chk_out("nomerge1", 1'b1, 8'h07, 4'h2, 2'b10);

    // Idle with ready_i: valid drops, data fields hold.
    drive(1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00, 1'b1);
    chk_rdy("idle", 1'b0, 1'b0);
    chk_out("idle", 1'b0, 8'h07, 4'h2, 2'b10);

    // Reset while an entry is pending and blocked.
    drive(1'b1, 4'h1, 8'h55, 1'b0, 4'h0, 8'h00, 1'b1);
    chk_out("pend", 1'b1, 8'h55, 4'h1, 2'b01);
    rst_i = 1'b1;
    drive(1'b0, 4'h0, 8'h00, 1'b1, 4'h4, 8'h66, 1'b0);
    chk_rdy("midrst", 1'b0, 1'b0);
    chk_out("midrst", 1'b0, 8'h00, 4'h0, 2'b00);
    rst_i = 1'b0;
    ready_i = 1'b1;
    chk_rdy("postrst", 1'b0, 1'b1);
    chk_out("postrst", 1'b1, 8'h66, 4'h4, 2'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
